ahb3lite_sram_slave: RTL and testbench

AHB3LITE_SRAM_SLAVE -- requirements
Module: ahb3lite_sram_slave

---
 rtl/ahb3lite_sram_slave.sv | 159 +++++++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite SRAM slave with wait states and two-cycle ERROR responses
// Combinational read port, byte-lane writes committed at the edge that ends the data phase.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                  IDX_W     = $clog2(MEM_WORDS);
  localparam int                  LANES     = HDATA_SIZE / 8;
  localparam logic [HADDR_SIZE:0] MEM_BYTES = (HADDR_SIZE + 1)'(MEM_WORDS * 4);
  localparam logic [3:0]          WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [HDATA_SIZE-1:0] mem [MEM_WORDS];

  logic             ready;
  logic             accept;
  logic             err_range;
  logic             err_size;
  logic             err_align;
  logic             err;
  logic             wr_en;
  logic [LANES-1:0] be;
  logic             unused_ok;

  // ERR2 completes the error response, so it may take a new address phase like IDLE.
  assign ready     = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept    = HSEL & HREADY & HTRANS[1] & ready;

  assign err_range = {1'b0, HADDR} >= MEM_BYTES;
  assign err_size  = HSIZE > 3'b010;
  assign err_align = ((HSIZE == 3'b001) && HADDR[0]) ||
                     ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign err       = err_range | err_size | err_align;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    write_d = write_q;
    size_d  = size_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        if (accept) begin
          write_d = HWRITE;
          size_d  = HSIZE[1:0];
          lane_d  = HADDR[1:0];
          idx_d   = HADDR[IDX_W+1:2];
          if (err) begin
            state_d = ST_ERR1;
          end else begin
            valid_d = 1'b1;
            if (WS != 4'd0) begin
              state_d = ST_WAIT;
              cnt_d   = WS;
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      write_q <= write_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    be = '0;
    case (size_q)
      2'b00:   be = LANES'(1) << lane_q;
      2'b01:   be = LANES'(2'b11) << {lane_q[1], 1'b0};
      default: be = '1;
    endcase
  end

  // A pending transfer is only ever valid while out of reset, so reset drops an in-flight write.
  assign wr_en = valid_q & write_q & ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HRDATA    = (valid_q & ~write_q) ? mem[idx_q] : '0;
  assign HREADYOUT = ready;
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - directed self-checking bench for ahb3lite_sram_slave
// dut0 runs with no wait states, dut3 with three; HREADY loops back from HREADYOUT.
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;

  typedef struct {
    logic        hsel;
    logic        hrdy;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_ready;
    logic        e_resp;
    logic [31:0] e_rdata;
  } vec_t;

  logic clk;
  int   checks;
  int   failures;

  logic        rst0, hsel0, hwrite0, hrdy0, hready0, hmastlock0;
  logic [31:0] haddr0, hwdata0, hrdata0;
  logic [2:0]  hsize0, hburst0;
  logic [3:0]  hprot0;
  logic [1:0]  htrans0;
  logic        hreadyout0, hresp0;

  logic        rst3, hsel3, hwrite3, hrdy3, hready3, hmastlock3;
  logic [31:0] haddr3, hwdata3, hrdata3;
  logic [2:0]  hsize3, hburst3;
  logic [3:0]  hprot3;
  logic [1:0]  htrans3;
  logic        hreadyout3, hresp3;

  assign hready0 = hreadyout0 & hrdy0;
  assign hready3 = hreadyout3 & hrdy3;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .HSEL(hsel0), .HADDR(haddr0), .HWDATA(hwdata0),
    .HWRITE(hwrite0), .HSIZE(hsize0), .HBURST(hburst0), .HPROT(hprot0),
    .HTRANS(htrans0), .HMASTLOCK(hmastlock0), .HREADY(hready0),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb3lite_sram_slave #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst3), .HSEL(hsel3), .HADDR(haddr3), .HWDATA(hwdata3),
    .HWRITE(hwrite3), .HSIZE(hsize3), .HBURST(hburst3), .HPROT(hprot3),
    .HTRANS(htrans3), .HMASTLOCK(hmastlock3), .HREADY(hready3),
    .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic hsel, input logic hrdy, input logic [1:0] trans,
                              input logic write, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic e_ready, input logic e_resp,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.hsel = hsel; v.hrdy = hrdy; v.trans = trans; v.write = write; v.size = size;
    v.addr = addr; v.wdata = wdata;
    v.e_ready = e_ready; v.e_resp = e_resp; v.e_rdata = e_rdata;
    return v;
  endfunction

  // One complete word transfer on dut3: three stalled cycles, then the ready cycle.
  task automatic txn3(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string nm);
    @(negedge clk);
    hsel3 = 1'b1; htrans3 = T_NS; hwrite3 = wr; haddr3 = addr; hsize3 = SZ_W;
    @(negedge clk);
    hsel3 = 1'b0; htrans3 = T_IDLE; hwdata3 = wdata;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s stall%0d", nm, k), {31'b0, hreadyout3}, 32'd0);
      @(negedge clk);
    end
    chk({nm, " ready"}, {31'b0, hreadyout3}, 32'd1);
    chk({nm, " resp"}, {31'b0, hresp3}, 32'd0);
    if (!wr) chk({nm, " rdata"}, hrdata3, exp);
  endtask

  vec_t vecs[$];

  initial begin
    checks = 0; failures = 0;
    rst0 = 1'b1; rst3 = 1'b1;
    hsel0 = 0; haddr0 = 0; hwdata0 = 0; hwrite0 = 0; hsize0 = SZ_W; htrans0 = T_IDLE;
    hburst0 = 0; hprot0 = 0; hmastlock0 = 0; hrdy0 = 1;
    hsel3 = 0; haddr3 = 0; hwdata3 = 0; hwrite3 = 0; hsize3 = SZ_W; htrans3 = T_IDLE;
    hburst3 = 0; hprot3 = 0; hmastlock3 = 0; hrdy3 = 1;

    vecs.push_back(mk(1, 1, T_NS,   1, SZ_W,   32'h000, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_W,   32'h010, 32'h01020304, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h010, 32'hDEADBEEF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'h0,        1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_W,   32'h010, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_B,   32'h013, 32'h11223344, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h010, 32'hAA5A5A5A, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_H,   32'h010, 32'h0,        1, 0, 32'hAA223344));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h010, 32'h12345566, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'h0,        1, 0, 32'hAA225566));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_W,   32'h400, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'hFFFFFFFF, 0, 1, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_W,   32'h002, 32'hFFFFFFFF, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'hFFFFFFFF, 0, 1, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   1, 3'b011, 32'h010, 32'hFFFFFFFF, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'hFFFFFFFF, 0, 1, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_H,   32'h011, 32'hFFFFFFFF, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'hFFFFFFFF, 0, 1, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h010, 32'hFFFFFFFF, 1, 1, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h000, 32'h0,        1, 0, 32'hAA225566));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'h0,        1, 0, 32'h01020304));
    vecs.push_back(mk(1, 1, T_BUSY, 1, SZ_W,   32'h010, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_NS,   1, SZ_W,   32'h010, 32'hFFFFFFFF, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_SEQ,  0, SZ_W,   32'h010, 32'hFFFFFFFF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'h0,        1, 0, 32'hAA225566));
    vecs.push_back(mk(1, 1, T_NS,   1, SZ_W,   32'h3FC, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h3FC, 32'hCAFEF00D, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'h0,        1, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, T_NS,   1, SZ_W,   32'h3FC, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 1, T_NS,   0, SZ_W,   32'h3FC, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, T_IDLE, 0, SZ_W,   32'h000, 32'h0,        1, 0, 32'hCAFEF00D));

    repeat (2) @(negedge clk);
    chk("rst0 ready", {31'b0, hreadyout0}, 32'd1);
    chk("rst0 resp",  {31'b0, hresp0},     32'd0);
    chk("rst0 rdata", hrdata0,             32'd0);
    chk("rst3 ready", {31'b0, hreadyout3}, 32'd1);
    chk("rst3 resp",  {31'b0, hresp3},     32'd0);
    chk("rst3 rdata", hrdata3,             32'd0);
    rst0 = 1'b0; rst3 = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      hsel0 = vecs[i].hsel; hrdy0 = vecs[i].hrdy; htrans0 = vecs[i].trans;
      hwrite0 = vecs[i].write; hsize0 = vecs[i].size; haddr0 = vecs[i].addr;
      hwdata0 = vecs[i].wdata;
      chk($sformatf("v%0d ready", i), {31'b0, hreadyout0}, {31'b0, vecs[i].e_ready});
      chk($sformatf("v%0d resp", i),  {31'b0, hresp0},     {31'b0, vecs[i].e_resp});
      chk($sformatf("v%0d rdata", i), hrdata0,             vecs[i].e_rdata);
    end
    @(negedge clk);
    hsel0 = 0; htrans0 = T_IDLE; hrdy0 = 1;

    // Read held on the bus during the write's stall: it must only be taken on the ready edge.
    @(negedge clk);
    hsel3 = 1; htrans3 = T_NS; hwrite3 = 1; haddr3 = 32'h0; hsize3 = SZ_W;
    @(negedge clk);
    hwrite3 = 0; hwdata3 = 32'h0BADF00D;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws_wr stall%0d", k), {31'b0, hreadyout3}, 32'd0);
      @(negedge clk);
    end
    chk("ws_wr ready", {31'b0, hreadyout3}, 32'd1);
    chk("ws_wr resp",  {31'b0, hresp3},     32'd0);
    @(negedge clk);
    hsel3 = 0; htrans3 = T_IDLE; hwdata3 = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ws_rd stall%0d", k), {31'b0, hreadyout3}, 32'd0);
      @(negedge clk);
    end
    chk("ws_rd ready", {31'b0, hreadyout3}, 32'd1);
    chk("ws_rd resp",  {31'b0, hresp3},     32'd0);
    chk("ws_rd rdata", hrdata3,             32'h0BADF00D);

    // Reset in the middle of a stalled write must abandon it.
    txn3(1'b1, 32'h20, 32'h0, 32'h0, "init20");
    @(negedge clk);
    hsel3 = 1; htrans3 = T_NS; hwrite3 = 1; haddr3 = 32'h20; hsize3 = SZ_W;
    @(negedge clk);
    hsel3 = 0; htrans3 = T_IDLE; hwdata3 = 32'h55555555;
    chk("rstw stall", {31'b0, hreadyout3}, 32'd0);
    #2 rst3 = 1'b1;
    #1;
    chk("rstw ready", {31'b0, hreadyout3}, 32'd1);
    chk("rstw resp",  {31'b0, hresp3},     32'd0);
    chk("rstw rdata", hrdata3,             32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    txn3(1'b0, 32'h20, 32'h0, 32'h0, "rd20");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
